source_logic: RTL and testbench
===============================

// Module: source_logic
// PURPOSE
//   Fixed 5-input, 1-output Boolean function block: y = 1 iff unsigned x is prime.
//   Exposes the result combinationally and as a registered copy.
//   Leaf decision block, driven from a 5-bit bus and feeding downstream control logic.
// PARAMETERS
//   None. Input width is fixed at 5 bits and output width at 1 bit.
// PORTS
//   Clocking: one clock; reset is asynchronous and active-low.
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  asynchronous active-low reset
//   y      out  1  combinational result, 1 iff x is prime
//   x      in   5  unsigned operand, 0..31
//   y_q    out  1  registered copy of y
//   Declaration order: y, x, clk, rst_n. Positional instantiation (y, x) stays valid.
// BEHAVIOUR
//   - Prime set: {2,3,5,7,11,13,17,19,23,29,31}. y=1 for these values, y=0 for all others.
//   - 0 and 1 are not prime, so y=0 for both.
//   - Equivalent mask: y = PRIME_MASK[x], PRIME_MASK = 32'hA08A_28AC.
//   - y is purely combinational from x:
//     - zero-cycle latency; must settle within one 20 ns stimulus step
//     - independent of clk and rst_n, including while reset is asserted
//     - no latches and no X propagation for any known x
//   - If x contains X or Z, y is X in simulation. No masking is applied.
//   - y_q timing:
//     - on each clk rising edge, y_q <= y
//     - latency exactly 1 cycle
//     - holds its value between edges
//   - Reset:
//     - rst_n=0 forces y_q=0 immediately (asynchronous), regardless of x
//     - while rst_n=0, y_q stays 0 on clock edges
//     - first capture is on the first rising edge after rst_n returns to 1
//   - Reset mid-operation: y_q clears at once; y continues to track x.
//   - If rst_n deasserts on the same edge as clk, the register takes reset priority for that edge.
//   - No handshake and no internal state beyond the y_q flop.
// STRUCTURE
//   - Package source_pkg holds:
//     - localparam X_W = 5
//     - localparam [31:0] PRIME_MASK = 32'hA08A_28AC
//     - function is_prime(input [4:0] v) returning PRIME_MASK[v]
//   - Sub-module source_prime_lut (combinational):
//     - 32-entry case statement on x, with a default of 0
//     - must agree with PRIME_MASK; the top level instantiates it and cross-checks in assertions
//   - Top level adds the single y_q flop with asynchronous active-low reset.
//   - Assertion: y == source_pkg::is_prime(x) whenever x is known.
// TESTING
//   - Exhaustive sweep, x = 0..31 in 20 ns steps:
//     - y=1 exactly at 2,3,5,7,11,13,17,19,23,29,31
//     - y=0 elsewhere, e.g. x=0,1,4,9,15,21,25,27
//   - Boundaries:
//     - x=5'b00000 -> y=0
//     - x=5'b00010 -> y=1
//     - x=5'b11110 -> y=0
//     - x=5'b11111 -> y=1
//   - Reset: hold rst_n=0 with x=7 -> y=1 and y_q=0; release, 1 edge later -> y_q=1.
//   - Latency: x 7->8 just before an edge -> y drops at once, y_q=0 after that edge.
//   - Mid-run reset: x=13 with y_q=1, pulse rst_n low between edges -> y_q=0 at once, y stays 1.
//   - Consistency: random x for 1000 cycles:
//     - y must always match the mask
//     - y_q must equal y from the previous cycle

Source files
------------

// File: rtl/source_pkg.sv
// Shared constants and the reference prime lookup for the 5-bit prime detector.
// PRIME_MASK bit n is set exactly when n is prime.
package source_pkg;

    localparam int X_W = 5;
    localparam logic [31:0] PRIME_MASK = 32'hA08A_28AC;

    function automatic logic is_prime(input logic [4:0] v);
        return PRIME_MASK[v];
    endfunction

endpackage

// File: rtl/source_prime_lut.sv
// Combinational 32-entry prime table over a 5-bit operand.
// This table is written out independently of PRIME_MASK, so the top level can cross-check the two.
module source_prime_lut
    import source_pkg::*;
(
    input  logic [X_W-1:0] x,
    output logic           y
);

    always_comb begin
        y = 1'b0;
        case (x)
            5'd0:    y = 1'b0;
            5'd1:    y = 1'b0;
            5'd2:    y = 1'b1;
            5'd3:    y = 1'b1;
            5'd4:    y = 1'b0;
            5'd5:    y = 1'b1;
            5'd6:    y = 1'b0;
            5'd7:    y = 1'b1;
            5'd8:    y = 1'b0;
            5'd9:    y = 1'b0;
            5'd10:   y = 1'b0;
            5'd11:   y = 1'b1;
            5'd12:   y = 1'b0;
            5'd13:   y = 1'b1;
            5'd14:   y = 1'b0;
            5'd15:   y = 1'b0;
            5'd16:   y = 1'b0;
            5'd17:   y = 1'b1;
            5'd18:   y = 1'b0;
            5'd19:   y = 1'b1;
            5'd20:   y = 1'b0;
            5'd21:   y = 1'b0;
            5'd22:   y = 1'b0;
            5'd23:   y = 1'b1;
            5'd24:   y = 1'b0;
            5'd25:   y = 1'b0;
            5'd26:   y = 1'b0;
            5'd27:   y = 1'b0;
            5'd28:   y = 1'b0;
            5'd29:   y = 1'b1;
            5'd30:   y = 1'b0;
            5'd31:   y = 1'b1;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/source_logic.sv
// Prime detector: combinational y = (x is prime) plus a one-cycle registered copy y_q.
// y_q clears asynchronously on rst_n low; y tracks x at all times, including during reset.
module source_logic
    import source_pkg::*;
(
    output logic           y,
    input  logic [X_W-1:0] x,
    input  logic           clk,
    input  logic           rst_n,
    output logic           y_q
);

    source_prime_lut u_lut (
        .x (x),
        .y (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

    // The hand-written table must agree with the packed mask whenever the operand is known.
    a_lut_matches_mask : assert property (
        @(posedge clk) !$isunknown(x) |-> (y == is_prime(x))
    );

endmodule

// File: tb/tb_source_logic.sv
// Self-checking bench for source_logic: reset, exhaustive sweep, boundaries, latency,
// mid-run reset and a random run checked against a trial-division prime model.
`timescale 1ns/1ps
module tb_source_logic;

    logic       clk;
    logic       rst_n;
    logic [4:0] x;
    logic       y;
    logic       y_q;

    int vectors;
    int miscompares;

    source_logic dut (
        .y     (y),
        .x     (x),
        .clk   (clk),
        .rst_n (rst_n),
        .y_q   (y_q)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic ref_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++) begin
            if (v % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        x     = 5'd7;
        #5;
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_y: got %b expected 1", y);
        end
        vectors++;
        if (y_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_yq: got %b expected 0", y_q);
        end
        // edges while held in reset must not capture
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_yq: got %b expected 0", y_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #5;
        vectors++;
        if (y_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_pre_edge: got %b expected 0", y_q);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_capture: got %b expected 1", y_q);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 32; v++) begin
            logic e;
            @(negedge clk);
            x = 5'(v);
            e = ref_prime(v);
            #5;
            vectors++;
            if (y !== e) begin
                miscompares++;
                $display("FAIL sweep_y x=%0d: got %b expected %b", v, y, e);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (y_q !== e) begin
                miscompares++;
                $display("FAIL sweep_yq x=%0d: got %b expected %b", v, y_q, e);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [4:0] bx [4];
        logic       be [4];
        bx[0] = 5'b00000; be[0] = 1'b0;
        bx[1] = 5'b00010; be[1] = 1'b1;
        bx[2] = 5'b11110; be[2] = 1'b0;
        bx[3] = 5'b11111; be[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = bx[i];
            #5;
            vectors++;
            if (y !== be[i]) begin
                miscompares++;
                $display("FAIL boundary x=%b: got %b expected %b", bx[i], y, be[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        x = 5'd7;
        @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_yq_7: got %b expected 1", y_q);
        end
        @(negedge clk);
        #8;
        x = 5'd8;
        #1;
        vectors++;
        if (y !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_y_8: got %b expected 0", y);
        end
        vectors++;
        if (y_q !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_yq_hold: got %b expected 1", y_q);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_yq_8: got %b expected 0", y_q);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        x = 5'd13;
        @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre_yq: got %b expected 1", y_q);
        end
        #4;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y_q !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_yq_clear: got %b expected 0", y_q);
        end
        vectors++;
        if (y !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_y_track: got %b expected 1", y);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (y_q !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_recapture: got %b expected 1", y_q);
        end
    endtask

    task automatic test_random();
        logic prev_e;
        prev_e = ref_prime(int'(x));
        for (int n = 0; n < 1000; n++) begin
            int   v;
            logic e;
            @(negedge clk);
            v = int'($urandom_range(0, 31));
            x = 5'(v);
            e = ref_prime(v);
            #5;
            vectors++;
            if (y !== e) begin
                miscompares++;
                $display("FAIL random_y x=%0d: got %b expected %b", v, y, e);
            end
            vectors++;
            if (y_q !== prev_e) begin
                miscompares++;
                $display("FAIL random_yq cycle=%0d: got %b expected %b", n, y_q, prev_e);
            end
            prev_e = e;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        x           = 5'd0;
        test_reset();
        test_sweep();
        test_boundaries();
        test_latency();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
